// File: rtl/led_fade_driver.sv
// led_fade_driver: turns the low NUM_LEDS bits of the SoC Counter into PWM-faded LED drive.
// Optional macro LED_FADE_GAMMA_EN selects a quadratic duty curve; the default is linear.
module led_fade_driver #(
  parameter int NUM_LEDS = 4,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 4096
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [7:0]                   Counter,
  input  logic                         Enable,
  output logic [NUM_LEDS-1:0]          LED,
  output logic                         Busy,
  output logic [2*NUM_LEDS-1:0]        dbg_state,
  output logic [NUM_LEDS*PWM_BITS-1:0] dbg_level
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PWM_BITS-1:0] MAX     = {PWM_BITS{1'b1}};
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    RISING  = 2'd1,
    ON      = 2'd2,
    FALLING = 2'd3
  } state_t;

  logic [NUM_LEDS-1:0] tgt_q, tgt_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PS_W-1:0]     ps_q, ps_d;
  logic                tick;
  state_t              st_q  [NUM_LEDS];
  state_t              st_d  [NUM_LEDS];
  logic [PWM_BITS-1:0] lvl_q [NUM_LEDS];
  logic [PWM_BITS-1:0] lvl_d [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                busy_q, busy_d;
  logic                unused_counter_bits;

  // Only the low NUM_LEDS bits are targets; the rest are intentionally dropped.
  assign unused_counter_bits = ^Counter;

  function automatic logic [PWM_BITS-1:0] duty_of(input logic [PWM_BITS-1:0] lvl);
`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, lvl};
    return sq[2*PWM_BITS-1:PWM_BITS];
`else
    return lvl;
`endif
  endfunction

  always_comb begin
    tgt_d = Counter[NUM_LEDS-1:0];
    pwm_d = pwm_q + 1'b1;
    tick  = Enable && (ps_q == PS_LAST);
    ps_d  = ps_q;
    if (Enable) ps_d = tick ? '0 : ps_q + 1'b1;
  end

  // Direction follows the target every enabled cycle; the level only moves on tick.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      st_d[i]  = st_q[i];
      lvl_d[i] = lvl_q[i];
      if (Enable) begin
        unique case (st_q[i])
          OFF: if (tgt_q[i]) st_d[i] = RISING;
          RISING: begin
            if (!tgt_q[i]) begin
              st_d[i] = FALLING;
            end else if (tick) begin
              lvl_d[i] = (lvl_q[i] == MAX) ? MAX : lvl_q[i] + 1'b1;
              if ((lvl_q[i] == MAX) || (lvl_q[i] == MAX - 1'b1)) st_d[i] = ON;
            end
          end
          ON: if (!tgt_q[i]) st_d[i] = FALLING;
          FALLING: begin
            if (tgt_q[i]) begin
              st_d[i] = RISING;
            end else if (tick) begin
              lvl_d[i] = (lvl_q[i] == '0) ? '0 : lvl_q[i] - 1'b1;
              if (lvl_q[i] <= PWM_BITS'(1)) st_d[i] = OFF;
            end
          end
          default: st_d[i] = OFF;
        endcase
      end
    end
  end

  always_comb begin
    led_d  = '0;
    busy_d = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if ((st_q[i] == RISING) || (st_q[i] == FALLING)) busy_d = 1'b1;
      if (Enable) begin
        unique case (st_q[i])
          ON:              led_d[i] = 1'b1;
          RISING, FALLING: led_d[i] = (duty_of(lvl_q[i]) > pwm_q);
          default:         led_d[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tgt_q  <= '0;
      pwm_q  <= '0;
      ps_q   <= '0;
      led_q  <= '0;
      busy_q <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        st_q[i]  <= OFF;
        lvl_q[i] <= '0;
      end
    end else begin
      tgt_q  <= tgt_d;
      pwm_q  <= pwm_d;
      ps_q   <= ps_d;
      led_q  <= led_d;
      busy_q <= busy_d;
      for (int i = 0; i < NUM_LEDS; i++) begin
        st_q[i]  <= st_d[i];
        lvl_q[i] <= lvl_d[i];
      end
    end
  end

  always_comb begin
    dbg_state = '0;
    dbg_level = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      dbg_state[2*i +: 2]               = st_q[i];
      dbg_level[i*PWM_BITS +: PWM_BITS] = lvl_q[i];
    end
  end

  assign LED  = led_q;
  assign Busy = busy_q;

endmodule
